// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with one-hot colour palette
// Optional feature macro: VGA_TEST_PATTERN_EN (adds test_mode input, 8 vertical colour bars)
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 4,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       pixel_color,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  output logic             pix_ce,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_active,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CW-1:0]    R,
  output logic [CW-1:0]    G,
  output logic [CW-1:0]    B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON    = 1'(HS_POL);
  localparam logic             VS_ON    = 1'(VS_POL);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_ce_q, pix_ce_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [CW-1:0]    r_q, r_d;
  logic [CW-1:0]    g_q, g_d;
  logic [CW-1:0]    b_q, b_d;

  logic             active;
  logic             hs_win;
  logic             vs_win;
  logic [7:0]       color_sel;
  logic [11:0]      pal_rgb;

  // Nominal 4-bit {R,G,B} for a one-hot colour; anything else is black.
  function automatic logic [11:0] palette(input logic [7:0] sel);
    case (sel)
      8'h01:   palette = 12'h000;
      8'h02:   palette = 12'h00F;
      8'h04:   palette = 12'hA22;
      8'h08:   palette = 12'hDFF;
      8'h10:   palette = 12'hF00;
      8'h20:   palette = 12'h808;
      8'h40:   palette = 12'hFF0;
      8'h80:   palette = 12'hFFF;
      default: palette = 12'h000;
    endcase
  endfunction

  // Replicate the nibble to 8 bits and keep the top CW bits so full scale stays full scale.
  function automatic logic [CW-1:0] widen(input logic [3:0] v);
    widen = CW'({v, v} >> (8 - CW));
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  logic [7:0] bar_color;

  // Bar index (h*8)/H_ACTIVE via constant thresholds ceil(k*H_ACTIVE/8); bar 0 is white.
  always_comb begin
    bar_color = 8'h80;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt_q >= CNT_W'((k * H_ACTIVE + 7) / 8)) begin
        bar_color = 8'h80 >> k;
      end
    end
  end

  assign color_sel = test_mode ? bar_color : pixel_color;
`else
  assign color_sel = pixel_color;
`endif

  // Clock divider and raster counters; counters step only on a pixel tick.
  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pix_ce_d = (div_q == DIV_LAST);
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    if (pix_ce_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  assign active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_win  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vs_win  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign pal_rgb = palette(color_sel);

  // Output stage: capture sync/de/RGB for the current coordinate on each tick, hold otherwise.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    if (pix_ce_q) begin
      hsync_d = hs_win ? HS_ON : ~HS_ON;
      vsync_d = vs_win ? VS_ON : ~VS_ON;
      de_d    = active;
      if (active) begin
        r_d = widen(pal_rgb[11:8]);
        g_d = widen(pal_rgb[7:4]);
        b_d = widen(pal_rgb[3:0]);
      end else begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
      end
    end
  end

  // State registers with asynchronous reset to the idle, blanked raster origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      hsync_q  <= ~HS_ON;
      vsync_q  <= ~VS_ON;
      de_q     <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign pix_x       = h_cnt_q;
  assign pix_y       = v_cnt_q;
  assign pix_active  = active;
  assign frame_start = pix_ce_q && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign R           = r_q;
  assign G           = g_q;
  assign B           = b_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator with an integrated one-hot colour palette.
- Derives a pixel clock-enable from the system clock by integer division and runs horizontal and vertical counters from it.
- Publishes the current raster coordinate to the pixel source (snake/board renderer), samples that source's 8-bit one-hot colour, and drives registered hsync/vsync/RGB, all aligned at one pixel tick latency.
- Sits between the game renderer and the board's VGA DAC pins.

Parameters:
- CLK_DIV, 2: clk cycles per pixel tick; must be >= 1; 1 means every clk cycle is a tick.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: hsync asserted level.
- VS_POL, 0: vsync asserted level.
- CW, 4: colour bits per channel, range 1..8.
- CNT_W, 11: coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- pixel_color, input, 8: one-hot colour for the coordinate currently on pix_x/pix_y.
- pix_ce, output, 1: pixel tick strobe, high for one clk cycle every CLK_DIV clk cycles.
- pix_x, output, CNT_W: current horizontal counter value.
- pix_y, output, CNT_W: current vertical counter value.
- pix_active, output, 1: current counter position is inside the visible region.
- frame_start, output, 1: one-clk pulse on the tick where counters are at (0,0).
- hsync, output, 1: registered horizontal sync.
- vsync, output, 1: registered vertical sync.
- de, output, 1: registered data-enable, aligned with RGB.
- R, output, CW: red channel.
- G, output, CW: green channel.
- B, output, CW: blue channel.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Divider:
  - Counts 0..CLK_DIV-1; pix_ce=1 when the divider is at CLK_DIV-1.
  - CLK_DIV=1 gives pix_ce constantly 1 after reset.
- Counters (advance only when pix_ce=1):
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on that same h wrap and wraps V_TOTAL-1 -> 0.
  - A single tick at (H_TOTAL-1, V_TOTAL-1) goes to (0,0).
- pix_x/pix_y equal h_cnt/v_cnt.
- pix_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- frame_start = pix_ce && h_cnt==0 && v_cnt==0.
- Sync windows:
  - hsync asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, evaluated per v_cnt for whole lines.
- Output stage, latency 1 pixel tick:
  - On each pix_ce, register hsync, vsync, de=pix_active and RGB computed from the current counters and pixel_color.
  - Outputs hold between ticks.
  - The RGB/sync seen after tick N corresponds to the coordinate presented before tick N.
- Palette (4-bit nominal R,G,B), selected by one-hot pixel_color:
  - 0x01: 0,0,0
  - 0x02: 0,0,F
  - 0x04: A,2,2
  - 0x08: D,F,F
  - 0x10: F,0,0
  - 0x20: 8,0,8
  - 0x40: F,F,0
  - 0x80: F,F,F
  - Any other value (zero or multi-hot): 0,0,0.
- Width rule: each 4-bit value v maps to CW bits as the top CW bits of the 8-bit {v,v}. For CW=4 the output is v; for CW=8 F->FF and A->AA.
- Blanking: when pix_active=0, the registered RGB is 0 regardless of pixel_color.
- Reset values (async, immediate on rst_n=0):
  - divider=0, h_cnt=0, v_cnt=0, pix_ce=0, frame_start=0.
  - hsync=~HS_POL, vsync=~VS_POL, de=0, R=G=B=0.
- Reset mid-frame aborts the line; after release, the first pix_ce occurs CLK_DIV cycles later at (0,0), so frame_start fires on that tick.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - Adds input test_mode (1 bit).
  - When test_mode=1, pixel_color is ignored and the active area shows 8 vertical bars using palette entries 0x80,0x40,0x20,0x10,0x08,0x04,0x02,0x01 in order.
  - Bar index = (h_cnt*8)/H_ACTIVE, computed with comparisons against constant boundaries (no divider).
  - Same latency and blanking as normal mode.
- When undefined: port absent; behaviour exactly as above.

Test Plan:
- Reset/divider: defaults, hold rst_n=0 for 5 clk then release -> hsync=1, vsync=1, RGB=0 during reset; first pix_ce at clk cycle 2 after release; frame_start coincident with it.
- Line timing: defaults, run one line -> hsync low for exactly 96 ticks starting at h_cnt=656; line period 800 ticks = 1600 clk; de high for 640 ticks.
- Frame timing: run two frames -> vsync low during v_cnt 490..491 (2 lines = 1600 ticks); frame_start pulses exactly 420000 ticks apart.
- Palette/latency: CW=4, pixel_color=0x04 at (10,10) -> after that tick R=A, G=2, B=2; 0x03 -> 0,0,0; 0x80 at h_cnt=700 -> RGB=0 (blanked).
- Width/small raster: CW=8, CLK_DIV=1, H_ACTIVE=8, V_ACTIVE=4, porches/syncs 1 -> pixel_color=0x10 gives R=FF, G=0, B=0; wrap (H_TOTAL-1, V_TOTAL-1)->(0,0) in one tick.
- Test pattern (VGA_TEST_PATTERN_EN): test_mode=1 -> at h_cnt=0 RGB=F,F,F; at h_cnt=80 RGB=F,F,0; at h_cnt=639 RGB=0,0,0; pixel_color changes have no effect.
